// File: rtl/mrv1_pkg.sv
// Shared core-wide definitions for the mrv1 multithreaded core.
// Holds the default datapath widths and the writeback request record used by the
// writeback arbiter and its per-source FIFOs.
package mrv1_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned NUM_THREADS   = 8;
  localparam int unsigned TID_WIDTH     = $clog2(NUM_THREADS);
  localparam int unsigned RF_ADDR_WIDTH = 5;

  localparam int unsigned WB_FIFO_DEPTH = 2;

  // One register writeback: which thread, which register, what value.
  typedef struct packed {
    logic [TID_WIDTH-1:0]     tid;
    logic [RF_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } wb_req_t;

endpackage

// File: rtl/mrv1_wb_fifo.sv
// 2-entry synchronous FIFO of writeback requests.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-low reset, empties the FIFO
//   push_i       write push_data_i at the tail (caller guarantees !full_o)
//   push_data_i  entry to write
//   pop_i        drop the head entry (caller guarantees !empty_o)
//   head_o       current head entry, valid when count_o != 0
//   count_o      number of entries held (0..2)
//   full_o       count_o == depth
//   empty_o      count_o == 0
module mrv1_wb_fifo
  import mrv1_pkg::*;
#(
  parameter type entry_t = wb_req_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  entry_t     push_data_i,
  input  logic       pop_i,
  output entry_t     head_o,
  output logic [1:0] count_o,
  output logic       full_o,
  output logic       empty_o
);

  entry_t     mem_q [WB_FIFO_DEPTH];
  entry_t     mem_d [WB_FIFO_DEPTH];
  logic [1:0] count_q, count_d;

  // Entries are kept shifted so that the head always sits in slot 0.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (push_i && pop_i) begin
      if (count_q == 2'd2) begin
        mem_d[0] = mem_q[1];
        mem_d[1] = push_data_i;
      end else begin
        mem_d[0] = push_data_i;
      end
    end else if (push_i) begin
      mem_d[count_q[0]] = push_data_i;
      count_d           = count_q + 2'd1;
    end else if (pop_i) begin
      mem_d[0] = mem_q[1];
      count_d  = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_q  <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign head_o  = mem_q[0];
  assign count_o = count_q;
  assign full_o  = (count_q == 2'(WB_FIFO_DEPTH));
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/mrv1_wb_arb.sv
// Writeback arbiter: buffers register writebacks from NUM_SRC_P functional units in
// per-source 2-entry FIFOs and grants at most one per cycle, round-robin, to the
// register file's single registered write port. Writes to x0 are drained silently.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-low reset
//   src_valid_i  per-source writeback request
//   src_ready_o  per-source FIFO can accept (low while in reset)
//   src_tid_i    per-source thread id, packed source-major
//   src_addr_i   per-source destination register, packed source-major
//   src_data_i   per-source result data, packed source-major
//   rd_w_en_o    register-file write enable (registered)
//   rd_tid_o     write thread (registered)
//   rd_addr_o    write register (registered)
//   rd_data_o    write data (registered)
//   idle_o       all FIFOs empty and no write in the output stage
module mrv1_wb_arb
  import mrv1_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_P    = DATA_WIDTH,
  parameter int unsigned NUM_THREADS_P   = NUM_THREADS,
  parameter int unsigned rf_addr_width_p = RF_ADDR_WIDTH,
  parameter int unsigned NUM_SRC_P       = 3,
  localparam int unsigned tid_width_lp   = $clog2(NUM_THREADS_P),
  localparam int unsigned src_width_lp   = $clog2(NUM_SRC_P)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_SRC_P-1:0]                  src_valid_i,
  output logic [NUM_SRC_P-1:0]                  src_ready_o,
  input  logic [NUM_SRC_P*tid_width_lp-1:0]     src_tid_i,
  input  logic [NUM_SRC_P*rf_addr_width_p-1:0]  src_addr_i,
  input  logic [NUM_SRC_P*DATA_WIDTH_P-1:0]     src_data_i,
  output logic                                  rd_w_en_o,
  output logic [tid_width_lp-1:0]               rd_tid_o,
  output logic [rf_addr_width_p-1:0]            rd_addr_o,
  output logic [DATA_WIDTH_P-1:0]               rd_data_o,
  output logic                                  idle_o
);

  // Same layout as wb_req_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [tid_width_lp-1:0]    tid;
    logic [rf_addr_width_p-1:0] addr;
    logic [DATA_WIDTH_P-1:0]    data;
  } req_t;

  req_t                   push_req [NUM_SRC_P];
  req_t                   head     [NUM_SRC_P];
  logic [1:0]             count    [NUM_SRC_P];
  logic [NUM_SRC_P-1:0]   push, pop, full, empty;

  for (genvar g = 0; g < NUM_SRC_P; g++) begin : g_src
    assign push_req[g].tid  = src_tid_i[g*tid_width_lp +: tid_width_lp];
    assign push_req[g].addr = src_addr_i[g*rf_addr_width_p +: rf_addr_width_p];
    assign push_req[g].data = src_data_i[g*DATA_WIDTH_P +: DATA_WIDTH_P];

    // Ready looks only at the current fill level, never at a same-cycle pop.
    assign src_ready_o[g] = rst_i && !full[g];
    assign push[g]        = src_valid_i[g] && src_ready_o[g];

    mrv1_wb_fifo #(
      .entry_t (req_t)
    ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push[g]),
      .push_data_i (push_req[g]),
      .pop_i       (pop[g]),
      .head_o      (head[g]),
      .count_o     (count[g]),
      .full_o      (full[g]),
      .empty_o     (empty[g])
    );
  end

  logic [src_width_lp-1:0]    rr_q, rr_d;
  logic                       rd_w_en_q, rd_w_en_d;
  logic [tid_width_lp-1:0]    rd_tid_q, rd_tid_d;
  logic [rf_addr_width_p-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH_P-1:0]    rd_data_q, rd_data_d;

  logic                       grant_vld;
  logic [src_width_lp-1:0]    grant_idx;

  // Rotating priority: scan from rr_q upward, wrapping, first non-empty FIFO wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned off = 0; off < NUM_SRC_P; off++) begin
      int unsigned idx;
      idx = int'(rr_q) + off;
      if (idx >= NUM_SRC_P) idx = idx - NUM_SRC_P;
      if (!grant_vld && count[idx] != 2'd0) begin
        grant_vld = 1'b1;
        grant_idx = src_width_lp'(idx);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC_P; i++) begin
      pop[i] = grant_vld && (grant_idx == src_width_lp'(i));
    end
  end

  always_comb begin
    rr_d      = rr_q;
    rd_w_en_d = 1'b0;
    rd_tid_d  = rd_tid_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (grant_vld) begin
      rr_d      = (grant_idx == src_width_lp'(NUM_SRC_P - 1)) ? '0 : grant_idx + 1'b1;
      // x0 entries are popped and captured but never enable the write.
      rd_w_en_d = (head[grant_idx].addr != '0);
      rd_tid_d  = head[grant_idx].tid;
      rd_addr_d = head[grant_idx].addr;
      rd_data_d = head[grant_idx].data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rr_q      <= '0;
      rd_w_en_q <= 1'b0;
      rd_tid_q  <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      rr_q      <= rr_d;
      rd_w_en_q <= rd_w_en_d;
      rd_tid_q  <= rd_tid_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_w_en_o = rd_w_en_q;
  assign rd_tid_o  = rd_tid_q;
  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;
  assign idle_o    = (&empty) && !rd_w_en_q;

endmodule

// File: tb/tb_mrv1_wb_arb.sv
// Bench for mrv1_wb_arb: directed scenarios followed by random traffic, checked by a
// queue-based reference model and a scoreboard monitor on the register-file port.
module tb_mrv1_wb_arb;
  import mrv1_pkg::*;

  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [NS-1:0] src_valid_i;
  logic [NS-1:0] src_ready_o;
  logic [NS*TID_WIDTH-1:0]     src_tid_i;
  logic [NS*RF_ADDR_WIDTH-1:0] src_addr_i;
  logic [NS*DATA_WIDTH-1:0]    src_data_i;
  logic                        rd_w_en_o;
  logic [TID_WIDTH-1:0]        rd_tid_o;
  logic [RF_ADDR_WIDTH-1:0]    rd_addr_o;
  logic [DATA_WIDTH-1:0]       rd_data_o;
  logic                        idle_o;

  always #5 clk = ~clk;

  mrv1_wb_arb dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .src_valid_i (src_valid_i),
    .src_ready_o (src_ready_o),
    .src_tid_i   (src_tid_i),
    .src_addr_i  (src_addr_i),
    .src_data_i  (src_data_i),
    .rd_w_en_o   (rd_w_en_o),
    .rd_tid_o    (rd_tid_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o),
    .idle_o      (idle_o)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int unsigned cyc;
    wb_req_t     req;
  } exp_t;

  exp_t    exp_q[$];       // expected register-file writes, tagged with their cycle
  wb_req_t mq[NS][$];      // reference model: per-source FIFO contents
  int      rr_m = 0;
  bit      wen_m = 1'b0;
  bit      pend_v[NS];
  wb_req_t pend[NS];
  bit      mon_en = 1'b0;
  exp_t    mon_e;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Scoreboard monitor on the write port.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_w_en_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_write", 64'(rd_w_en_o), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("wr_tid", 64'(rd_tid_o), 64'(mon_e.req.tid));
          chk("wr_addr", 64'(rd_addr_o), 64'(mon_e.req.addr));
          chk("wr_data", 64'(rd_data_o), 64'(mon_e.req.data));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        chk("missing_write", 64'(rd_w_en_o), 64'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  // One clock: drive pending requests, check ready/idle, advance the model one edge.
  task automatic step(input bit rst_n);
    bit      idle_exp;
    bit      acc[NS];
    bit      got;
    int      g;
    wb_req_t h;
    @(negedge clk);
    idle_exp = !wen_m;
    for (int i = 0; i < NS; i++) if (mq[i].size() != 0) idle_exp = 1'b0;
    chk("idle", 64'(idle_o), 64'(idle_exp));
    rst_i = rst_n;
    for (int i = 0; i < NS; i++) begin
      src_valid_i[i]                              = pend_v[i];
      src_tid_i[i*TID_WIDTH +: TID_WIDTH]         = pend[i].tid;
      src_addr_i[i*RF_ADDR_WIDTH +: RF_ADDR_WIDTH] = pend[i].addr;
      src_data_i[i*DATA_WIDTH +: DATA_WIDTH]      = pend[i].data;
    end
    #1;
    for (int i = 0; i < NS; i++) begin
      acc[i] = rst_n && (mq[i].size() < 2);
      chk($sformatf("ready%0d", i), 64'(src_ready_o[i]), 64'(acc[i]));
    end
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      rr_m  = 0;
      wen_m = 1'b0;
    end else begin
      got = 1'b0;
      g   = 0;
      for (int off = 0; off < NS; off++) begin
        int idx;
        idx = (rr_m + off) % NS;
        if (!got && mq[idx].size() > 0) begin
          got = 1'b1;
          g   = idx;
          h   = mq[idx].pop_front();
        end
      end
      for (int i = 0; i < NS; i++) begin
        if (pend_v[i] && acc[i]) begin
          mq[i].push_back(pend[i]);
          pend_v[i] = 1'b0;
        end
      end
      wen_m = 1'b0;
      if (got) begin
        rr_m  = (g + 1) % NS;
        wen_m = (h.addr != 0);
        if (wen_m) exp_q.push_back('{cyc + 1, h});
      end
    end
  endtask

  task automatic req(input int s, input int tid, input int addr, input logic [31:0] data);
    int n = 0;
    while (pend_v[s] && n < 20) begin
      step(1'b1);
      n++;
    end
    chk("req_slot_free", 64'(pend_v[s]), 64'd0);
    pend[s].tid  = TID_WIDTH'(tid);
    pend[s].addr = RF_ADDR_WIDTH'(addr);
    pend[s].data = data;
    pend_v[s]    = 1'b1;
  endtask

  task automatic run_clear(input int n);
    for (int k = 0; k < n; k++) step(1'b1);
    for (int k = 0; k < 20 && (pend_v[0] || pend_v[1] || pend_v[2]); k++) step(1'b1);
    chk("pending_accepted", 64'({pend_v[0], pend_v[1], pend_v[2]}), 64'd0);
  endtask

  task automatic chk_rd_zero();
    @(posedge clk);
    #1;
    chk("rst_w_en", 64'(rd_w_en_o), 64'd0);
    chk("rst_tid", 64'(rd_tid_o), 64'd0);
    chk("rst_addr", 64'(rd_addr_o), 64'd0);
    chk("rst_data", 64'(rd_data_o), 64'd0);
  endtask

  initial begin
    rst_i       = 1'b0;
    src_valid_i = '0;
    src_tid_i   = '0;
    src_addr_i  = '0;
    src_data_i  = '0;
    for (int i = 0; i < NS; i++) begin
      pend_v[i] = 1'b0;
      pend[i]   = '0;
    end
    @(posedge clk);
    chk_rd_zero();
    mon_en = 1'b1;

    // single write
    req(0, 3, 5, 32'hDEADBEEF);
    run_clear(4);

    // x0 write is drained without a write pulse
    req(1, 6, 0, 32'h1234);
    run_clear(4);

    // round-robin from rr = 0: two entries per source in consecutive cycles
    step(1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < NS; s++) req(s, s + 1, 8 * r + s + 1, 32'hA000_0000 + 32'(16 * r + s));
      step(1'b1);
    end
    run_clear(8);

    // backpressure on source 2 while 0 and 1 are also loaded
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < 2; s++) if (!pend_v[s]) req(s, 2, 10 + s, 32'hB000_0000 + 32'(r * 4 + s));
      req(2, 7, 20 + r, 32'hC000_0000 + 32'(r));
      step(1'b1);
    end
    run_clear(10);

    // push on source 0 in the cycle its single entry is granted
    req(0, 1, 3, 32'h1111_1111);
    step(1'b1);
    req(0, 1, 4, 32'h2222_2222);
    run_clear(4);

    // reset while entries are buffered
    for (int s = 0; s < NS; s++) req(s, s, 9 + s, 32'hD000_0000 + 32'(s));
    step(1'b1);
    req(0, 4, 17, 32'hE000_0000);
    req(1, 5, 18, 32'hE000_0001);
    step(1'b1);
    for (int s = 0; s < NS; s++) pend_v[s] = 1'b0;
    step(1'b0);
    chk_rd_zero();
    run_clear(4);

    // random traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      for (int s = 0; s < NS; s++) begin
        if (!pend_v[s] && $urandom_range(0, 1) == 1) begin
          pend[s].tid  = TID_WIDTH'($urandom);
          pend[s].addr = ($urandom_range(0, 7) == 0) ? '0 : RF_ADDR_WIDTH'($urandom);
          pend[s].data = $urandom;
          pend_v[s]    = 1'b1;
        end
      end
      step($urandom_range(0, 299) != 0);
    end

    run_clear(10);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
